alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor of the single-cycle ALU for the rv32i core. It executes the full RV32I integer op set plus an iterative unsigned multiply/divide extension, and registers every result. A valid/ready pair on both sides lets the control unit stall while a multi-cycle operation runs. It sits between the register-file read ports and the writeback mux.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts a new op; high only in IDLE.
- alu_op  in  4  operation code (see Operation).
- in_1, in_2  in  WIDTH  operands.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  registered result.
- zero  out  1  ~|out, derived from the result register.
- busy  out  1  high in BUSY.

## Operation
- Op codes keep the existing 4-bit encoding and add new ones:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - SLL 0100, SRL 0101, SUB 0110, SRA 0111
  - SLT 1000, SLTU 1001
  - MUL 1010, DIVU 1011, REMU 1100
  - 1101–1111 execute as AND.
- Single-cycle class: every op except MUL, DIVU and REMU.
- Shifts use only in_2[SHW-1:0]. SRA replicates in_1[WIDTH-1].
- SLT is a signed compare; SLTU is unsigned. Both return 1 or 0, zero-extended to WIDTH.
- ADD, SUB and MUL wrap modulo 2^WIDTH. MUL returns the low WIDTH bits of the unsigned product.
- DIVU and REMU use a restoring algorithm, one quotient bit per cycle.
- Divide by zero: DIVU returns all ones; REMU returns in_1. Neither raises an error and neither takes extra cycles.
- State machine:
  - IDLE -> DONE when in_valid and the op is single-cycle; the result is latched that edge.
  - IDLE -> BUSY when in_valid and the op is iterative; the operands are latched and the counter loaded with WIDTH.
  - BUSY decrements the counter each cycle. It moves to DONE on the edge where the counter goes 1 -> 0, latching the final result.
  - DONE -> IDLE when out_ready.
- Operands are captured at acceptance. Changes on in_1, in_2 or alu_op after acceptance have no effect.

## Timing
- Reset values (asynchronous, immediate): state IDLE, in_ready 1, out_valid 0, busy 0, out 0, zero 1, counter 0.
- Latency from acceptance edge to first out_valid cycle:
  - single-cycle ops: 1 cycle.
  - iterative ops: WIDTH+1 cycles.
- Throughput: no overlap. The earliest next acceptance is the cycle after out_valid && out_ready.
- out and zero hold stable while out_valid is high and out_ready is low.
- in_valid in BUSY or DONE is ignored (in_ready is 0). It is not queued.
- out_ready while out_valid is 0 has no effect.
- Reset asserted mid-operation (BUSY or DONE) aborts the op with no output. Behaviour after release is as from power-up.

## Structure
- Shared package alu_pkg holds:
  - op-code localparams (AND … REMU);
  - state encoding (IDLE, BUSY, DONE);
  - an is_iterative(op) function.
  The control unit imports the same package.
- Sub-module alu_iter, parametrised by WIDTH, contains:
  - the shift-add multiplier and restoring divider datapath;
  - the counter;
  - a done pulse.
- The top level holds the FSM, the single-cycle datapath and the result register.

## Test plan
- Reset mid-BUSY: start DIVU, assert rst_n=0 on cycle 5 -> out_valid=0, out=0, zero=1, in_ready=1 immediately; the next op completes normally.
- Single-cycle sweep, WIDTH=32:
  - ADD 0xFFFFFFFF+1 -> out=0, zero=1;
  - SUB 5-7 -> 0xFFFFFFFE;
  - SRA 0x80000000 by 33 (uses 1) -> 0xC0000000;
  - SLT -1,1 -> 1;
  - SLTU -1,1 -> 0;
  - op 1111 with 0xF0,0x3C -> 0x30.
  All with out_valid exactly 1 cycle after acceptance.
- MUL 0x0001_0000 × 0x0001_0003 -> out=0x0003_0000, out_valid 33 cycles after acceptance; busy high for 32 cycles.
- DIVU 100/7 -> 14, REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF and REMU 9/0 -> 9, with the same 33-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after ADD 2+3 -> out=5 stable, in_ready=0, and a second in_valid is ignored. Release -> IDLE next cycle.
- Re-run the MUL and DIVU cases at WIDTH=8: 0x0F × 0x11 -> 0xFF, latency 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM state encoding, op-class helper.
// Also imported by the control unit, so keep encodings stable.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Latency: WIDTH cycles after start; done is high in the cycle whose edge retires the last step.
// Backpressure: none; the caller only pulses start when it can take the result.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // hi holds the accumulator (MUL) or partial remainder (DIV); lo holds
    // the multiplier or the dividend being shifted out / quotient shifted in.
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        rem_sh = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd_q};
        if (start) begin
            cnt_d  = CW'(WIDTH);
            hi_d   = '0;
            lo_d   = in_1;
            opnd_d = in_2;
            op_d   = op;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
                if (lo_q[0]) begin
                    hi_d = hi_q + {1'b0, opnd_q};
                end
                lo_d   = lo_q >> 1;
                opnd_d = opnd_q << 1;
            end else if (!trial[WIDTH]) begin
                // A zero divisor always lands here: quotient all ones, remainder = dividend.
                hi_d = trial;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh;
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= OP_AND;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
        end
    end

    assign done   = (cnt_q == CW'(1));
    assign result = (op_q == OP_DIVU) ? lo_d : hi_d[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I ALU with iterative MUL/DIVU/REMU and a registered result.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for iterative ops; no overlap between ops.
// Backpressure: result holds in DONE until out_ready; in_ready only in IDLE, nothing is queued.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] sc_res;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;

    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign iter_start = accept && is_iterative(alu_op);
    assign shamt      = in_2[SHW-1:0];

    always_comb begin
        sc_res = in_1 & in_2;
        case (alu_op)
            OP_OR:   sc_res = in_1 | in_2;
            OP_ADD:  sc_res = in_1 + in_2;
            OP_XOR:  sc_res = in_1 ^ in_2;
            OP_SLL:  sc_res = in_1 << shamt;
            OP_SRL:  sc_res = in_1 >> shamt;
            OP_SUB:  sc_res = in_1 - in_2;
            OP_SRA:  sc_res = $signed(in_1) >>> shamt;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in_1 < in_2)};
            default: sc_res = in_1 & in_2;
        endcase
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .op     (alu_op),
        .in_1   (in_1),
        .in_2   (in_2),
        .done   (iter_done),
        .result (iter_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = is_iterative(alu_op) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The result register only moves on entry to DONE, so out is stable under backpressure.
    always_comb begin
        out_d = out_q;
        if (accept && !is_iterative(alu_op)) begin
            out_d = sc_res;
        end else if ((state_q == ST_BUSY) && iter_done) begin
            out_d = iter_res;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_BUSY);
    end

    assign out  = out_q;
    assign zero = ~|out_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32 and WIDTH=8: directed table, corner sequences, random vs model.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  alu_op;
    logic [31:0] in_1, in_2, out;

    logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_zero, v8_busy;
    logic [3:0]  v8_op;
    logic [7:0]  v8_a, v8_b, v8_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .in_1(in_1), .in_2(in_2), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .alu_op(v8_op), .in_1(v8_a), .in_2(v8_b), .out_valid(v8_out_valid),
        .out_ready(v8_out_ready), .out(v8_out), .zero(v8_zero), .busy(v8_busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return a << sh;
            4'd5:  return a >> sh;
            4'd6:  return a - b;
            4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin prod = longint'(a) * longint'(b); return prod[31:0]; end
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return a & b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input int w);
        return (op >= 4'd10 && op <= 4'd12) ? w + 1 : 1;
    endfunction

    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
        int lat;
        int bcnt;
        chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_op = op; in_1 = a; in_2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_op = 4'($urandom); in_1 = $urandom; in_2 = $urandom;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 200) begin
            bcnt += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat(op, 32)));
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'(exp_lat(op, 32) - 1));
        chk({nm, " out"}, out, exp);
        chk({nm, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string nm);
        int lat;
        v8_in_valid = 1'b1; v8_op = op; v8_a = a; v8_b = b;
        @(posedge clk); #1;
        v8_in_valid = 1'b0; v8_a = 8'($urandom); v8_b = 8'($urandom);
        lat = 1;
        while (!v8_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat(op, 8)));
        chk({nm, " out"}, {24'd0, v8_out}, {24'd0, exp});
        v8_out_ready = 1'b1;
        @(posedge clk); #1;
        v8_out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0};
        tbl[1]  = '{OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE};
        tbl[2]  = '{OP_SRA,  32'h8000_0000, 32'd33,        32'hC000_0000};
        tbl[3]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1};
        tbl[4]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0};
        tbl[5]  = '{4'b1111, 32'hF0,        32'h3C,        32'h30};
        tbl[6]  = '{OP_MUL,  32'h0001_0000, 32'h0001_0003, 32'h0003_0000};
        tbl[7]  = '{OP_DIVU, 32'd100,       32'd7,         32'd14};
        tbl[8]  = '{OP_REMU, 32'd100,       32'd7,         32'd2};
        tbl[9]  = '{OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF};
        tbl[10] = '{OP_REMU, 32'd9,         32'd0,         32'd9};
        tbl[11] = '{OP_SLL,  32'd1,         32'd35,        32'd8};
        tbl[12] = '{OP_SRL,  32'h8000_0000, 32'd31,        32'd1};
        tbl[13] = '{OP_XOR,  32'hA5A5,      32'hFFFF,      32'h5A5A};
        tbl[14] = '{OP_OR,   32'hF0,        32'h0F,        32'hFF};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; alu_op = 4'd0; in_1 = '0; in_2 = '0;
        v8_in_valid = 1'b0; v8_out_ready = 1'b0; v8_op = 4'd0; v8_a = '0; v8_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset out", out, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd1);
        chk("reset8 out", {24'd0, v8_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Backpressure: result must hold and a second request must be dropped.
        in_valid = 1'b1; alu_op = OP_ADD; in_1 = 32'd2; in_2 = 32'd3;
        @(posedge clk); #1;
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; alu_op = OP_SUB; in_1 = 32'd9; in_2 = 32'd1;
            chk($sformatf("bp hold out c%0d", i), out, 32'd5);
            chk($sformatf("bp in_ready c%0d", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("bp not queued", {31'd0, out_valid}, 32'd0);

        // Reset mid-BUSY on cycle 5 of a DIVU.
        in_valid = 1'b1; alu_op = OP_DIVU; in_1 = 32'd1000; in_2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst out", out, 32'd0);
        chk("midrst zero", {31'd0, zero}, 32'd1);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run32(OP_DIVU, 32'd1000, 32'd3, 32'd333, "after_rst divu");

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run32(op, a, b, model(op, a, b), $sformatf("rnd%0d op%0d", i, op));
        end

        run8(OP_MUL,  8'h0F, 8'h11, 8'hFF, "w8 mul");
        run8(OP_DIVU, 8'd100, 8'd7, 8'd14, "w8 divu");
        run8(OP_REMU, 8'd100, 8'd7, 8'd2,  "w8 remu");
        run8(OP_DIVU, 8'd9,   8'd0, 8'hFF, "w8 divu0");
        run8(OP_REMU, 8'd9,   8'd0, 8'd9,  "w8 remu0");
        run8(OP_ADD,  8'hFF,  8'd1, 8'd0,  "w8 add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
